// File: rtl/rom_download_bridge.sv
`timescale 1ns/1ps
// rom_download_bridge: packs data_io byte strobes into 16-bit byte-masked SDRAM
// write requests on a toggle handshake, and sequences rom_loaded / core reset.
module rom_download_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_HOLD = 16
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        ioctl_download_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_dout_i,
  input  logic        user_reset_i,
  output logic        port_req_o,
  input  logic        port_ack_i,
  output logic [22:0] port_a_o,
  output logic [1:0]  port_ds_o,
  output logic [15:0] port_d_o,
  output logic        port_we_o,
  output logic        rom_loaded_o,
  output logic        core_reset_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              HW        = $clog2(RESET_HOLD + 1);
  localparam logic [PW:0]     FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RESET_HOLD - 1);

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } req_t;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_WAIT} state_t;

  logic w_unused_addr;
  assign w_unused_addr = ioctl_addr_i[24];

  logic        r_wr_prev, r_dl_prev;
  logic        r_pend_v;
  logic [23:0] r_pend_a;
  logic [7:0]  r_pend_d;
  logic        w_event, w_dl_rise, w_dl_fall, w_merge;
  logic [23:0] w_addr;

  assign w_addr    = ioctl_addr_i[23:0];
  assign w_event   = ioctl_download_i & ioctl_wr_i & ~r_wr_prev;
  assign w_dl_rise = ioctl_download_i & ~r_dl_prev;
  assign w_dl_fall = ~ioctl_download_i & r_dl_prev;
  assign w_merge   = r_pend_v & w_addr[0] & (w_addr == r_pend_a + 24'd1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_wr_prev <= 1'b0;
      r_dl_prev <= 1'b0;
      r_pend_v  <= 1'b0;
      r_pend_a  <= '0;
      r_pend_d  <= '0;
    end else begin
      r_wr_prev <= ioctl_wr_i;
      r_dl_prev <= ioctl_download_i;
      if (w_event) begin
        if (w_merge) begin
          r_pend_v <= 1'b0;
        end else begin
          r_pend_v <= 1'b1;
          r_pend_a <= w_addr;
          r_pend_d <= ioctl_dout_i;
        end
      end else if (w_dl_fall) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  logic w_push;
  req_t w_push_ent;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_push        = 1'b0;
    w_push_ent.a  = r_pend_a[23:1];
    w_push_ent.ds = r_pend_a[0] ? 2'b10 : 2'b01;
    w_push_ent.d  = {r_pend_d, r_pend_d};
    if (w_event) begin
      if (w_merge) begin
        w_push        = 1'b1;
        w_push_ent.a  = w_addr[23:1];
        w_push_ent.ds = 2'b11;
        w_push_ent.d  = {ioctl_dout_i, r_pend_d};
      end else begin
        w_push = r_pend_v;
      end
    end else if (w_dl_fall) begin
      w_push = r_pend_v;
    end
  end

  req_t          r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_full, w_empty, w_pop, w_accept;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_accept = w_push & (~w_full | w_pop);

  // NOTE: the storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_push_ent;
  end

  logic r_overflow;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
      else if (w_dl_rise)           r_overflow <= 1'b0;
    end
  end

  // The issued entry moves into the port registers, so all FIFO slots stay free for new requests.
  state_t r_state, w_state_nxt;
  logic   r_req, w_issue;
  req_t   r_port;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_SYNC: if (port_ack_i == r_req) w_state_nxt = S_IDLE;
      S_IDLE: if (!w_empty) begin
        w_issue     = 1'b1;
        w_pop       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (port_ack_i == r_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_state <= S_SYNC;
      r_req   <= 1'b0;
      r_port  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_port <= r_mem[r_rd_ptr];
        r_req  <= ~r_req;
      end
    end
  end

  logic          w_quiet;
  logic [HW-1:0] r_hold;
  logic          r_rom_loaded, r_core_reset;

  assign w_quiet = ~ioctl_download_i & ~r_pend_v & w_empty & (r_state == S_IDLE);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_hold       <= '0;
      r_rom_loaded <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_core_reset <= user_reset_i | ~r_rom_loaded;
      if (w_dl_rise) begin
        r_hold       <= '0;
        r_rom_loaded <= 1'b0;
      end else if (!w_quiet) begin
        r_hold <= '0;
      end else if (!r_rom_loaded) begin
        if (r_hold == HOLD_LAST) r_rom_loaded <= 1'b1;
        else                     r_hold       <= r_hold + HW'(1);
      end
    end
  end

  assign busy_o       = r_pend_v | ~w_empty | (r_state == S_WAIT);
  assign port_we_o    = ioctl_download_i | busy_o;
  assign port_req_o   = r_req;
  assign port_a_o     = r_port.a;
  assign port_ds_o    = r_port.ds;
  assign port_d_o     = r_port.d;
  assign rom_loaded_o = r_rom_loaded;
  assign core_reset_o = r_core_reset;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_rom_download_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for rom_download_bridge: stimulus pushes expected SDRAM words
// into a queue; an SDRAM responder process pops and compares each issued request.
module tb_rom_download_bridge;

  localparam int FIFO_DEPTH = 4;
  localparam int RESET_HOLD = 16;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_reset = 1'b0;
  logic        port_req;
  logic        port_ack = 1'b0;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we, rom_loaded, core_reset, overflow, busy;

  always #5 clk = ~clk;

  rom_download_bridge #(.FIFO_DEPTH(FIFO_DEPTH), .RESET_HOLD(RESET_HOLD)) dut (
    .clk_i(clk), .res_n_i(rst_n),
    .ioctl_download_i(ioctl_download), .ioctl_wr_i(ioctl_wr),
    .ioctl_addr_i(ioctl_addr), .ioctl_dout_i(ioctl_dout),
    .user_reset_i(user_reset),
    .port_req_o(port_req), .port_ack_i(port_ack),
    .port_a_o(port_a), .port_ds_o(port_ds), .port_d_o(port_d),
    .port_we_o(port_we), .rom_loaded_o(rom_loaded), .core_reset_o(core_reset),
    .overflow_o(overflow), .busy_o(busy)
  );

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_req = 0;
  logic  resp_en = 1'b0;
  logic  stall = 1'b0;
  logic  ack_ovr = 1'b0;

  // Reference model state: the byte waiting for its partner.
  logic        m_pv = 1'b0;
  logic [23:0] m_pa = '0;
  logic [7:0]  m_pd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic word_t mk(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    word_t w;
    w.a = a; w.ds = ds; w.d = d;
    return w;
  endfunction

  function automatic word_t lone(input logic [23:0] a, input logic [7:0] d);
    return mk(a[23:1], a[0] ? 2'b10 : 2'b01, {d, d});
  endfunction

  // Byte-level model: an odd byte directly following a held byte completes a word.
  task automatic model_byte(input logic [23:0] a, input logic [7:0] d);
    if (m_pv && a[0] && (a == m_pa + 24'd1)) begin
      exp_q.push_back(mk(a[23:1], 2'b11, {d, m_pd}));
      m_pv = 1'b0;
    end else begin
      if (m_pv) exp_q.push_back(lone(m_pa, m_pd));
      m_pv = 1'b1; m_pa = a; m_pd = d;
    end
  endtask

  task automatic model_flush();
    if (m_pv) exp_q.push_back(lone(m_pa, m_pd));
    m_pv = 1'b0;
  endtask

  // SDRAM side: detects a new toggle, scores it, holds it for a random latency, then acks.
  initial begin : responder
    bit    seen;
    int    dly;
    word_t held, e;
    seen = 1'b0; dly = 0; held = '0; e = '0;
    forever begin
      @(negedge clk);
      if (!resp_en || !rst_n) begin
        seen     = 1'b0;
        port_ack = ack_ovr;
      end else if (!seen && port_req != port_ack) begin
        seen = 1'b1;
        n_req++;
        held = {port_a, port_ds, port_d};
        dly  = $urandom_range(0, 1);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: got a=0x%0h ds=%b d=0x%0h, expected no request",
                   port_a, port_ds, port_d);
        end else begin
          e = exp_q.pop_front();
          check("req_word", held, e);
        end
      end else if (seen) begin
        check("req_stable", {port_a, port_ds, port_d}, held);
        if (!stall) begin
          if (dly == 0) begin
            port_ack = port_req;
            seen     = 1'b0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_raw(input logic [24:0] a, input logic [7:0] d, input int hi, input int lo);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    repeat (hi) @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic set_dl(input logic v);
    ioctl_download = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, (t < 500) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},      port_req, 0);
    check({tag, "_a"},        port_a, 0);
    check({tag, "_ds"},       port_ds, 0);
    check({tag, "_d"},        port_d, 0);
    check({tag, "_we"},       port_we, 0);
    check({tag, "_loaded"},   rom_loaded, 0);
    check({tag, "_core_rst"}, core_reset, 1);
    check({tag, "_ovf"},      overflow, 0);
    check({tag, "_busy"},     busy, 0);
  endtask

  // Download low is driven just before the edge that samples it; rom_loaded must
  // appear on exactly the RESET_HOLD-th edge after that.
  task automatic check_completion(input string tag);
    ioctl_download = 1'b0;
    for (int i = 1; i < RESET_HOLD; i++) @(negedge clk);
    check({tag, "_loaded_early"}, rom_loaded, 0);
    @(negedge clk);
    check({tag, "_loaded"}, rom_loaded, 1);
    check({tag, "_core_rst_hold"}, core_reset, 1);
    @(negedge clk);
    check({tag, "_core_rst_rel"}, core_reset, 0);
  endtask

  initial begin : stimulus
    int          n0;
    logic        req0, req_exp;
    logic [7:0]  lo_b, hi_b;
    logic [23:0] last_a;
    logic [24:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst_in");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_out");
    resp_en = 1'b1;

    // Paired bytes and request latency
    set_dl(1'b1);
    exp_q.push_back(mk(23'd0, 2'b11, 16'h2211));
    send_raw(25'd0, 8'h11, 1, 3);
    ioctl_addr = 25'd1; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    req0 = port_req;
    @(negedge clk);
    check("pair_req_edge_n", port_req, req0);
    @(negedge clk);
    req_exp = ~req0;
    check("pair_req_edge_n1", port_req, req_exp);
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
    set_dl(1'b0);
    drain("pair_drain");

    // Lone bytes: odd then non-adjacent even, flushed at download end
    set_dl(1'b1);
    n0 = n_req;
    exp_q.push_back(mk(23'd2, 2'b10, 16'hAAAA));
    exp_q.push_back(mk(23'd4, 2'b01, 16'hBBBB));
    send_raw(25'd5, 8'hAA, 1, 4);
    send_raw(25'd8, 8'hBB, 1, 4);
    check("lone_before_end", n_req - n0, 1);
    set_dl(1'b0);
    drain("lone_drain");
    check("lone_total", n_req - n0, 2);

    // Held strobe counts once
    set_dl(1'b1);
    n0 = n_req;
    exp_q.push_back(mk(23'd1, 2'b01, 16'h3333));
    send_raw(25'd2, 8'h33, 6, 4);
    check("held_no_req", n_req - n0, 0);
    check("held_busy", busy, 1);
    set_dl(1'b0);
    drain("held_drain");
    check("held_total", n_req - n0, 1);

    // Stalled ack: one in flight plus FIFO_DEPTH queued, the rest dropped
    stall = 1'b1;
    set_dl(1'b1);
    n0 = n_req;
    for (int k = 0; k < 10; k++) begin
      lo_b = 8'($urandom); hi_b = 8'($urandom);
      if (k < FIFO_DEPTH + 1) exp_q.push_back(mk(23'h100 + 23'(k), 2'b11, {hi_b, lo_b}));
      send_raw(25'h200 + 25'(2 * k), lo_b, 1, 2);
      send_raw(25'h201 + 25'(2 * k), hi_b, 1, 2);
    end
    check("stall_in_flight", n_req - n0, 1);
    check("stall_overflow", overflow, 1);
    set_dl(1'b0);
    repeat (4) @(negedge clk);
    check("stall_overflow_sticky", overflow, 1);
    stall = 1'b0;
    drain("stall_drain");
    check("stall_total", n_req - n0, FIFO_DEPTH + 1);
    set_dl(1'b1);
    check("overflow_cleared", overflow, 0);

    // Completion, core reset, user reset, restart by a new download
    check_completion("cmp1");
    user_reset = 1'b1;
    @(negedge clk);
    check("user_rst_on", core_reset, 1);
    user_reset = 1'b0;
    @(negedge clk);
    check("user_rst_off", core_reset, 0);
    set_dl(1'b1);
    check("loaded_cleared", rom_loaded, 0);
    ioctl_download = 1'b0;
    repeat (8) @(negedge clk);
    set_dl(1'b1);
    check_completion("cmp2");

    // Randomised downloads against the byte-level model
    last_a = '0;
    for (int it = 0; it < 6; it++) begin
      set_dl(1'b1);
      m_pv = 1'b0;
      for (int b = 0; b < $urandom_range(20, 40); b++) begin
        if ($urandom_range(0, 1) == 1) a = {1'($urandom), last_a + 24'd1};
        else                           a = 25'($urandom);
        last_a = a[23:0];
        lo_b   = 8'($urandom);
        model_byte(a[23:0], lo_b);
        send_raw(a, lo_b, $urandom_range(1, 4), $urandom_range(4, 8));
      end
      model_flush();
      set_dl(1'b0);
      for (int s = 0; s < $urandom_range(0, 3); s++)
        send_raw(25'($urandom), 8'($urandom), 1, 2);
      drain("rand_drain");
      check("rand_no_overflow", overflow, 0);
    end

    // Reset in WAIT with a stale ack afterwards
    ack_ovr = port_ack;
    resp_en = 1'b0;
    @(negedge clk);
    set_dl(1'b1);
    send_raw(25'h10, 8'h5A, 1, 4);
    send_raw(25'h11, 8'hA5, 1, 4);
    check("rst_mid_wait_busy", busy, 1);
    rst_n = 1'b0;
    ioctl_download = 1'b0;
    ack_ovr = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_mid_in");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid_out");
    set_dl(1'b1);
    send_raw(25'h20, 8'hC3, 1, 4);
    send_raw(25'h21, 8'h3C, 1, 4);
    check("sync_holds_req", port_req, 0);
    check("sync_busy", busy, 1);
    ack_ovr = 1'b0;
    @(negedge clk);
    exp_q.push_back(mk(23'h10, 2'b11, 16'h3CC3));
    resp_en = 1'b1;
    set_dl(1'b0);
    drain("sync_drain");
    check("sync_req_issued", port_req, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
